climate_ctrl: RTL

Parametrised multi-zone air-conditioning controller. It is the next generation of the single-zone heating/cooling block. Each of `N_ZONES` zones runs its own hysteresis state machine on a `W`-bit temperature input. Each state machine enforces a minimum-on time and a minimum-off time to protect the plant, and is gated by a global operating mode. It sits between the temperature sensor interface and the heater/cooler drive outputs.

---
 rtl/climate_ctrl_if.sv | 23 ++
 rtl/climate_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/climate_ctrl_if.sv
// Sensor/drive bundle for the multi-zone climate controller.
// The master supplies mode and temperatures; the slave returns drives and status.
interface climate_ctrl_if #(
    parameter int N_ZONES = 2,
    parameter int W       = 5
);
    logic [1:0]                       mode;
    logic [N_ZONES*W-1:0]             temperature;
    logic [N_ZONES-1:0]               heating;
    logic [N_ZONES-1:0]               cooling;
    logic [2*N_ZONES-1:0]             zone_state;
    logic [$clog2(N_ZONES+1)-1:0]     active_cnt;

    modport master (
        output mode, temperature,
        input  heating, cooling, zone_state, active_cnt
    );

    modport slave (
        input  mode, temperature,
        output heating, cooling, zone_state, active_cnt
    );
endinterface

// File: rtl/climate_ctrl.sv
// Multi-zone hysteresis heat/cool controller with per-zone minimum on/off dwell.
// Each zone is an independent IDLE/HEAT/COOL FSM gated by the shared mode.
module climate_ctrl #(
    parameter int N_ZONES  = 2,
    parameter int W        = 5,
    parameter int HEAT_ON  = 18,
    parameter int HEAT_OFF = 20,
    parameter int COOL_ON  = 22,
    parameter int COOL_OFF = 20,
    parameter int MIN_ON   = 4,
    parameter int MIN_OFF  = 4
) (
    input  logic          clk,
    input  logic          rst,
    climate_ctrl_if.slave bus
);
    localparam int MAXD = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int AW   = $clog2(N_ZONES + 1);

    localparam logic [W-1:0]  T_HEAT_ON  = W'(HEAT_ON);
    localparam logic [W-1:0]  T_HEAT_OFF = W'(HEAT_OFF);
    localparam logic [W-1:0]  T_COOL_ON  = W'(COOL_ON);
    localparam logic [W-1:0]  T_COOL_OFF = W'(COOL_OFF);
    localparam logic [CW-1:0] LOAD_ON    = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] LOAD_OFF   = CW'(MIN_OFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10
    } state_t;

    state_t          state_q [N_ZONES];
    state_t          state_d [N_ZONES];
    logic [CW-1:0]   cnt_q   [N_ZONES];
    logic [CW-1:0]   cnt_d   [N_ZONES];
    logic [N_ZONES-1:0] heat_d;
    logic [N_ZONES-1:0] cool_d;
    logic [AW-1:0]      act_d;
    logic               heat_ok;
    logic               cool_ok;

    assign heat_ok = bus.mode[0];
    assign cool_ok = bus.mode[1];

    always_comb begin
        logic [W-1:0] t;
        t      = '0;
        heat_d = '0;
        cool_d = '0;
        act_d  = '0;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            t          = bus.temperature[i*W +: W];
            state_d[i] = state_q[i];
            cnt_d[i]   = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
            case (state_q[i])
                IDLE: begin
                    if (cnt_q[i] == '0 && heat_ok && t < T_HEAT_ON) begin
                        state_d[i] = HEAT;
                        cnt_d[i]   = LOAD_ON;
                    end else if (cnt_q[i] == '0 && cool_ok && t > T_COOL_ON) begin
                        state_d[i] = COOL;
                        cnt_d[i]   = LOAD_ON;
                    end
                end
                // A mode change forces exit regardless of the remaining on-time.
                HEAT: begin
                    if (!heat_ok || (cnt_q[i] == '0 && t >= T_HEAT_OFF)) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = LOAD_OFF;
                    end
                end
                COOL: begin
                    if (!cool_ok || (cnt_q[i] == '0 && t <= T_COOL_OFF)) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = LOAD_OFF;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            heat_d[i] = (state_d[i] == HEAT);
            cool_d[i] = (state_d[i] == COOL);
            act_d     = act_d + AW'(heat_d[i] | cool_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            bus.heating    <= '0;
            bus.cooling    <= '0;
            bus.active_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ZONES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            bus.heating    <= heat_d;
            bus.cooling    <= cool_d;
            bus.active_cnt <= act_d;
        end
    end

    always_comb begin
        bus.zone_state = '0;
        for (int unsigned i = 0; i < N_ZONES; i++) begin
            bus.zone_state[2*i +: 2] = state_q[i];
        end
    end
endmodule
